// File: rtl/cfg_shift_driver.sv
// cfg_shift_driver: MSB-first serializer for the config shift chain; CFG_SHIFT_LATCH_EN adds a latch strobe state.
// Latency: done at 1+2*DIV*WIDTH clk after handshake (+2*DIV with latch); cfg_ready low while busy, no queue.
module cfg_shift_driver #(
    parameter int WIDTH = 32,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             sclk,
    output logic             sdo,
    output logic             cfg_latch,
    output logic             done
);

    localparam int DCW = $clog2(DIV) + 1;
    localparam int BCW = $clog2(WIDTH) + 1;

    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_LOAD = BCW'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
`ifdef CFG_SHIFT_LATCH_EN
        S_LATCH,
`endif
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DCW-1:0]   r_div_cnt;
    logic [DCW-1:0]   w_div_nxt;
    logic [BCW-1:0]   r_bit_cnt;
    logic [BCW-1:0]   w_bit_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;

    logic             r_ready;
    logic             r_sclk;
    logic             r_sdo;
    logic             r_done;
    logic             w_ready_nxt;
    logic             w_sclk_nxt;
    logic             w_sdo_nxt;
    logic             w_done_nxt;
    logic             w_div_zero;

    assign w_div_zero = (r_div_cnt == '0);

    // Every state that counts reloads the divider on entry and leaves when it reaches zero.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid && r_ready) begin
                    w_state_nxt = S_LOW;
                    w_shreg_nxt = cfg_data;
                    w_bit_nxt   = BIT_LOAD;
                    w_div_nxt   = DIV_LAST;
                end
            end
            S_LOW: begin
                if (w_div_zero) begin
                    w_state_nxt = S_HIGH;
                    w_div_nxt   = DIV_LAST;
                end else begin
                    w_div_nxt = r_div_cnt - DCW'(1);
                end
            end
            S_HIGH: begin
                if (w_div_zero) begin
                    w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                    w_bit_nxt   = r_bit_cnt - BCW'(1);
                    if (r_bit_cnt == BCW'(1)) begin
`ifdef CFG_SHIFT_LATCH_EN
                        w_state_nxt = S_LATCH;
                        w_div_nxt   = DCW'(2 * DIV - 1);
`else
                        w_state_nxt = S_DONE;
                        w_div_nxt   = '0;
`endif
                    end else begin
                        w_state_nxt = S_LOW;
                        w_div_nxt   = DIV_LAST;
                    end
                end else begin
                    w_div_nxt = r_div_cnt - DCW'(1);
                end
            end
`ifdef CFG_SHIFT_LATCH_EN
            S_LATCH: begin
                if (w_div_zero) begin
                    w_state_nxt = S_DONE;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt = r_div_cnt - DCW'(1);
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so each one comes straight off a flop.
    always_comb begin
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_sclk_nxt  = (w_state_nxt == S_HIGH);
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_sdo_nxt   = 1'b0;
        if (w_state_nxt == S_LOW) begin
            w_sdo_nxt = w_shreg_nxt[WIDTH-1];
        end else if (w_state_nxt == S_HIGH) begin
            w_sdo_nxt = r_sdo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_ready   <= 1'b0;
            r_sclk    <= 1'b0;
            r_sdo     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shreg   <= w_shreg_nxt;
            r_ready   <= w_ready_nxt;
            r_sclk    <= w_sclk_nxt;
            r_sdo     <= w_sdo_nxt;
            r_done    <= w_done_nxt;
        end
    end

`ifdef CFG_SHIFT_LATCH_EN
    logic r_latch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latch <= 1'b0;
        end else begin
            r_latch <= (w_state_nxt == S_LATCH);
        end
    end

    assign cfg_latch = r_latch;
`else
    assign cfg_latch = 1'b0;
`endif

    assign cfg_ready = r_ready;
    assign sclk      = r_sclk;
    assign sdo       = r_sdo;
    assign done      = r_done;

endmodule

// File: tb/tb_cfg_shift_driver.sv
// Bench for cfg_shift_driver: two instances (DIV=2 and DIV=1), directed words, scoreboard-checked receiver model.
module tb_cfg_shift_driver;

    localparam int W = 32;
`ifdef CFG_SHIFT_LATCH_EN
    localparam int LEN = 1;
`else
    localparam int LEN = 0;
`endif

    logic         clk;
    logic         rst_n;
    logic [W-1:0] data [2];
    logic [1:0]   valid;
    logic [1:0]   ready;
    logic [1:0]   sclk;
    logic [1:0]   sdo;
    logic [1:0]   latch;
    logic [1:0]   done;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    cfg_shift_driver #(.WIDTH(W), .DIV(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_data(data[0]), .cfg_valid(valid[0]),
        .cfg_ready(ready[0]), .sclk(sclk[0]), .sdo(sdo[0]), .cfg_latch(latch[0]), .done(done[0])
    );

    cfg_shift_driver #(.WIDTH(W), .DIV(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_data(data[1]), .cfg_valid(valid[1]),
        .cfg_ready(ready[1]), .sclk(sclk[1]), .sdo(sdo[1]), .cfg_latch(latch[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dv(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic check(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h (cycle %0d)", nm, i, act, exp, cyc);
        end
    endtask

    // scoreboard: expected words pushed by stimulus, handshake times by the monitor
    logic [W-1:0] exp_m [2][16];
    int           exp_wr [2];
    int           exp_rd [2];
    int           hs_m [2][16];
    int           hs_wr [2];
    int           hs_rd [2];

    logic [W-1:0] rx [2];
    int           rise [2];
    int           hi [2];
    int           lat_cnt [2];
    int           lat_first [2];
    bit           busy [2];
    bit           rdy_bad [2];
    bit           hold_bad [2];
    bit           lat_bad [2];
    bit           after_done [2];
    logic         p_sclk [2];
    logic         p_sdo [2];
    logic         p_done [2];
    logic [W-1:0] ew;
    int           hs_now;

    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_wr[i] = 0; exp_rd[i] = 0; hs_wr[i] = 0; hs_rd[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                rx[i] = '0; rise[i] = 0; hi[i] = 0; lat_cnt[i] = 0; lat_first[i] = 0;
                busy[i] = 0; rdy_bad[i] = 0; hold_bad[i] = 0; lat_bad[i] = 0; after_done[i] = 0;
                exp_rd[i] = exp_wr[i];
                hs_rd[i] = hs_wr[i];
            end else begin
                if (busy[i] && ready[i]) rdy_bad[i] = 1;
                if (after_done[i]) begin
                    check("ready_after_done", i, 64'(ready[i]), 64'd1);
                    after_done[i] = 0;
                end
                if (valid[i] && ready[i]) begin
                    hs_m[i][hs_wr[i] % 16] = cyc;
                    hs_wr[i]++;
                    busy[i] = 1;
                end
                if (sclk[i]) hi[i]++;
                if (sclk[i] && !p_sclk[i]) begin
                    if (hs_rd[i] != hs_wr[i] && exp_rd[i] != exp_wr[i] && rise[i] < W) begin
                        hs_now = hs_m[i][hs_rd[i] % 16];
                        ew = exp_m[i][exp_rd[i] % 16];
                        check("rise_time", i, 64'(cyc - hs_now), 64'(1 + dv(i) + 2 * dv(i) * rise[i]));
                        check("sdo_setup", i, 64'(sdo[i]), 64'(p_sdo[i]));
                        check("sdo_bit", i, 64'(sdo[i]), 64'(ew[W-1-rise[i]]));
                    end
                    rx[i] = {rx[i][W-2:0], sdo[i]};
                    rise[i]++;
                end
                if (sclk[i] && p_sclk[i] && (sdo[i] !== p_sdo[i])) hold_bad[i] = 1;
                if (latch[i]) begin
                    if (lat_cnt[i] == 0) lat_first[i] = cyc;
                    lat_cnt[i]++;
                    if (sclk[i]) lat_bad[i] = 1;
                end
                if (done[i]) begin
                    check("done_width", i, 64'(p_done[i]), 64'd0);
                    if (exp_rd[i] == exp_wr[i] || hs_rd[i] == hs_wr[i]) begin
                        check("done_expected", i, 64'd1, 64'd0);
                    end else begin
                        hs_now = hs_m[i][hs_rd[i] % 16];
                        ew = exp_m[i][exp_rd[i] % 16];
                        hs_rd[i]++;
                        exp_rd[i]++;
                        check("rx_word", i, 64'(rx[i]), 64'(ew));
                        check("rise_count", i, 64'(rise[i]), 64'(W));
                        check("done_latency", i, 64'(cyc - hs_now), 64'(1 + 2 * dv(i) * (W + LEN)));
                        check("sclk_high_cycles", i, 64'(hi[i]), 64'(dv(i) * W));
                        check("latch_cycles", i, 64'(lat_cnt[i]), 64'(2 * dv(i) * LEN));
                        check("proto_flags", i, 64'({rdy_bad[i], hold_bad[i], lat_bad[i]}), 64'd0);
`ifdef CFG_SHIFT_LATCH_EN
                        check("latch_start", i, 64'(lat_first[i] - hs_now), 64'(1 + 2 * dv(i) * W));
`endif
                    end
                    rx[i] = '0; rise[i] = 0; hi[i] = 0; lat_cnt[i] = 0;
                    rdy_bad[i] = 0; hold_bad[i] = 0; lat_bad[i] = 0;
                    busy[i] = 0;
                    after_done[i] = 1;
                end
            end
            p_sclk[i] = sclk[i];
            p_sdo[i]  = sdo[i];
            p_done[i] = done[i];
        end
    end

    task automatic send(input int i, input logic [W-1:0] w, input bit keep, input bit scramble);
        int n;
        @(posedge clk); #1;
        data[i]  = w;
        valid[i] = 1'b1;
        exp_m[i][exp_wr[i] % 16] = w;
        exp_wr[i]++;
        n = 0;
        while (!ready[i] && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) check("accept_timeout", i, 64'd1, 64'd0);
        @(posedge clk); #1;
        if (!keep) valid[i] = 1'b0;
        if (scramble) begin
            repeat (150) begin
                @(posedge clk); #1;
                data[i] = $urandom;
            end
        end
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (exp_rd[i] != exp_wr[i] && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) check("done_timeout", i, 64'd1, 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        check("ready_at_release", 0, 64'(ready), 64'd0);
        @(posedge clk); #1;
        check("ready_first_clk", 0, 64'(ready), 64'd3);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        valid = '0;
        data[0] = '0;
        data[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            check("reset_outputs", i, 64'({ready[i], sclk[i], sdo[i], latch[i], done[i]}), 64'd0);
        release_reset();

        send(0, 32'hA5C3_0F81, 0, 0);
        wait_idle(0);
        send(1, 32'hAAAA_AAAA, 0, 0);
        wait_idle(1);

        // second word waits with cfg_valid held through the whole first transfer
        send(0, 32'hDEAD_BEEF, 1, 0);
        send(0, 32'h1234_5678, 0, 0);
        wait_idle(0);

        send(0, 32'h0F0F_3C3C, 0, 1);
        wait_idle(0);
        send(1, 32'h8000_0001, 0, 0);
        wait_idle(1);

        // abort mid-word after ten bits have gone out
        send(0, 32'hFFFF_0000, 0, 0);
        n = 0;
        while (rise[0] < 10 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("rise_timeout", 0, 64'd1, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_transfer", 0, 64'({ready[0], sclk[0], sdo[0], latch[0], done[0]}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        release_reset();

        send(0, 32'h1357_9BDF, 0, 0);
        wait_idle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
